// File: rtl/u2_zm_pkg.sv
// Shared types for the bit-serial U2 -> sign-magnitude converter.
package u2_zm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ST_DONE = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_NEG  = 3;

endpackage

// File: rtl/u2_to_zm_seq.sv
// Bit-serial two's complement to sign-magnitude converter: copies bits up to
// and including the first 1, inverts the rest, one bit per clock.
module u2_to_zm_seq
    import u2_zm_pkg::*;
#(
    parameter int M = 8,
    parameter int K = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [M-1:0] i_arg_A,
    output logic [K-1:0] cache_result,
    output logic [3:0]   cache_status
);

    localparam int CW = (M > 2) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 2);

    state_t         state;
    logic [M-1:0]   opnd;
    logic [M-2:0]   mag;
    logic [CW-1:0]  cnt;
    logic           seen;
    logic           neg;

    logic           x;
    logic           mbit;
    logic           seen_n;
    logic [M-2:0]   mag_n;
    logic [K-1:0]   res_n;

    // Operand shifts out LSB first; magnitude shifts in from the top so the
    // final bit lands in mag[0].
    always_comb begin
        x      = opnd[0];
        mbit   = neg ? (x ^ seen) : x;
        seen_n = seen | x;
        mag_n  = mag >> 1;
        mag_n[M-2] = mbit;
        res_n  = '0;
        res_n[M-2:0] = mag_n;
        if (neg && !seen_n) begin
            // Most-negative input: magnitude 2^(M-1) needs an extra bit.
            if (K == M) res_n = '1;
            else        res_n[M-1] = 1'b1;
        end
        res_n[K-1] = neg;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            opnd         <= '0;
            mag          <= '0;
            cnt          <= '0;
            seen         <= 1'b0;
            neg          <= 1'b0;
            cache_result <= '0;
            cache_status <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        opnd                 <= i_arg_A;
                        neg                  <= i_arg_A[M-1];
                        cnt                  <= '0;
                        seen                 <= 1'b0;
                        mag                  <= '0;
                        cache_status[ST_DONE] <= 1'b0;
                        cache_status[ST_OVF]  <= 1'b0;
                        cache_status[ST_BUSY] <= 1'b1;
                        cache_status[ST_NEG]  <= i_arg_A[M-1];
                        state                <= CONV;
                    end
                end
                CONV: begin
                    opnd <= opnd >> 1;
                    seen <= seen_n;
                    mag  <= mag_n;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state                 <= DONE;
                        cache_result          <= res_n;
                        cache_status[ST_BUSY] <= 1'b0;
                        cache_status[ST_DONE] <= 1'b1;
                        cache_status[ST_OVF]  <= (K == M) && neg && !seen_n;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/u2_to_zm_seq.md
Name: u2_to_zm_seq

Overview:
- Sequential, bit-serial converter from two's complement (U2) to sign-magnitude (ZM).
- It is the reverse-direction partner of the combinational ZM-to-U2 converter.
- It sits in the same arithmetic submodule set and drives the same cache_result/cache_status pair, so the top-level result mux treats both converters alike.
- It computes the magnitude one bit per clock using the "copy up to and including the first 1, then invert" rule, which trades latency for area.

Parameters:
- M, 8, input word width in bits (M >= 2).
- K, 8, output word width in bits (K >= M). Sign is at bit K-1; magnitude is zero-extended in bits K-2:0.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  request to convert i_arg_A; sampled on rising edge.
- i_arg_A  input  M  U2 operand; sampled only on the accepting edge.
- cache_result  output  K  ZM result; held until the next accepted start or reset.
- cache_status  output  4  [0] done, [1] busy, [2] overflow, [3] negative input.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high; when sampled high, all state clears on that edge.
- Reset values: state=IDLE, cache_result=0, cache_status=4'b0000, internal shift register, bit counter and seen_one flag all 0.
- States:
  - IDLE: waiting for i_start.
  - CONV: processing magnitude bits.
  - DONE: result valid.
- IDLE/DONE with i_start=1:
  - Latch i_arg_A.
  - Set neg = i_arg_A[M-1], counter=0, seen_one=0.
  - Clear done, overflow and the result magnitude; set busy.
  - Set status[3]=neg.
  - Go to CONV.
- CONV, one edge per bit idx = 0..M-2:
  - x = operand bit idx.
  - Magnitude bit: neg ? (x XOR seen_one) : x.
  - seen_one <= seen_one OR x.
  - On idx=M-2, go to DONE; write cache_result = {neg, zero-extension, magnitude[M-2:0]}; busy=0, done=1.
- Latency: the accepting edge is edge 0. Result and done are visible after edge M-1, which is 7 cycles for M=8. Throughput is one conversion per M-1 cycles plus the restart edge.
- i_start while in CONV: ignored. The operand is not re-latched and the conversion continues.
- i_start in DONE: accepted on that edge. The old result stays on cache_result until the new result is written at the end of CONV (done drops, busy rises).
- Most-negative input 100..0:
  - If K == M: overflow. Set status[2]=1 and saturate cache_result = {1, all ones} = -(2^(M-1)-1).
  - If K > M: no overflow. cache_result = {1, 0..0, 1, (M-1) zeros}, i.e. magnitude 2^(M-1).
- Zero input: result 0, neg=0. Negative zero is never produced.
- Reset mid-CONV: the reset edge wins over all activity. Return to IDLE with all outputs 0; a simultaneous i_start is ignored.
- Status bits are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package u2_zm_pkg holds:
  - The state enum (IDLE, CONV, DONE) as a 2-bit typedef.
  - Status bit index constants: ST_DONE=0, ST_BUSY=1, ST_OVF=2, ST_NEG=3.
- No sub-module. The serial step is one line of logic inside the FSM register block. The counter width is $clog2(M).

Test Plan:
- M=K=8, start with 0x05 -> busy for 7 cycles; then cache_result=0x05, status=4'b0001.
- M=K=8, start with 0xFB (-5) -> after 7 cycles cache_result=0x85, status=4'b1001. Start with 0xFF -> 0x81; start with 0x00 -> 0x00, status=4'b0001.
- M=K=8, start with 0x80 -> cache_result=0xFF, status=4'b1101. Same test with K=9: 0x80 -> 9'h180, status=4'b1001.
- Start with 0xFB, then pulse i_start with 0x05 on cycle 3 -> ignored; result 0x85. Back-to-back start in DONE with 0x05 -> 0x85 held during CONV, then 0x05.
- Start with 0xFB, assert i_rst on cycle 4 together with i_start -> next cycle state IDLE, cache_result=0, status=0; no conversion follows.
- Sweep all 256 8-bit inputs back-to-back -> each result matches the reference model: sign-magnitude of the value, saturated for -128.
